cfg_bank: RTL and testbench

Parametrised system configuration register bank on the PI bus. Accepted writes land in a shadow register set and are copied atomically to the live set on a commit write. Protected bits are guarded by an unlock key. Each volume channel glides to its target in unit steps. It sits beside the PI address map, and its live outputs drive cart, save-state, key and audio logic.

---
 rtl/cfg_bank_pkg.sv | 44 ++++
 rtl/cfg_bank_if.sv | 15 +
 rtl/cfg_bank_vol_ramp.sv | 45 ++++
 rtl/cfg_bank.sv | 168 ++++++++++++++++
 tb/tb_cfg_bank.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_bank_pkg.sv
// cfg_bank_pkg: shared constants for the configuration register bank.
// Imported by the bank RTL, the PI address map and the firmware header
// generator, so everything firmware-visible lives here:
//   CFG_UNLOCK_KEY          value written to A_LOCK that opens protected bits
//   CMT_APPLY / CMT_DISCARD bit positions in a commit write
//   ST_*                    bit layout of the status byte read at A_CMT
//   a_lock() / a_cmt()      reserved addresses for a given register count
package cfg_bank_pkg;

    localparam logic [7:0] CFG_UNLOCK_KEY = 8'hA5;

    localparam int CMT_APPLY   = 0;
    localparam int CMT_DISCARD = 1;

    localparam int ST_PEND     = 0;
    localparam int ST_UNLOCKED = 1;
    localparam int ST_BUSY     = 2;

    typedef enum logic [1:0] {
        ACC_DATA = 2'd0,
        ACC_LOCK = 2'd1,
        ACC_CMT  = 2'd2
    } acc_kind_t;

    function automatic int a_lock(input int reg_num);
        return reg_num - 2;
    endfunction

    function automatic int a_cmt(input int reg_num);
        return reg_num - 1;
    endfunction

    function automatic logic [7:0] status_byte(input logic pend,
                                               input logic unlocked,
                                               input logic busy);
        logic [7:0] s;
        s              = 8'h00;
        s[ST_PEND]     = pend;
        s[ST_UNLOCKED] = unlocked;
        s[ST_BUSY]     = busy;
        return s;
    endfunction

endpackage

// File: rtl/cfg_bank_if.sv
// cfg_bank_if: the subset of the PI bus seen by the configuration bank.
//   we_sync  write strobe, already synchronised to clk
//   addr     register address (AW bits)
//   dato     write data
// master drives the bus, slave (the bank) only observes it.
interface cfg_bank_if #(
    parameter int AW = 4
);
    logic          we_sync;
    logic [AW-1:0] addr;
    logic [7:0]    dato;

    modport master (output we_sync, output addr, output dato);
    modport slave  (input  we_sync, input  addr, input  dato);
endinterface

// File: rtl/cfg_bank_vol_ramp.sv
// vol_ramp: one volume glide channel.
// On every tick the output moves one unit toward the target and holds once
// equal, so it can never overshoot or wrap.
//   clk, rst   system clock, synchronous active-high reset
//   tick_i     step enable from the shared divider in cfg_bank
//   target_i   live target register
//   rst_val_i  value loaded on reset
//   vol_o      current ramped volume
//   busy_o     vol_o differs from target_i
module vol_ramp (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_i,
    input  logic [7:0] target_i,
    input  logic [7:0] rst_val_i,
    output logic [7:0] vol_o,
    output logic       busy_o
);

    logic [7:0] vol_q;
    logic [7:0] vol_d;

    always_comb begin
        vol_d = vol_q;
        if (tick_i) begin
            if (vol_q < target_i) begin
                vol_d = vol_q + 8'd1;
            end else if (vol_q > target_i) begin
                vol_d = vol_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vol_q <= rst_val_i;
        end else begin
            vol_q <= vol_d;
        end
    end

    assign vol_o  = vol_q;
    assign busy_o = (vol_q != target_i);

endmodule

// File: rtl/cfg_bank.sv
// cfg_bank: configuration register bank with shadow/live sets, unlock key
// for protected bits, and per-channel volume glides.
//   clk, rst      system clock, synchronous active-high reset
//   pi            PI bus slave view (we_sync, addr, dato)
//   ce_i          bank chip-select
//   cfg_o         live registers (A_LOCK / A_CMT read as 0)
//   vol_o         ramped volume per channel, target is cfg_o[1+c]
//   rd_dat_o      registered readback of pi.addr
//   pend_o        shadow holds uncommitted writes
//   ramp_busy_o   some channel has not reached its target
module cfg_bank
    import cfg_bank_pkg::*;
#(
    parameter int REG_NUM  = 16,
    parameter int CH_NUM   = 2,
    parameter int RAMP_DIV = 256,
    parameter logic [REG_NUM*8-1:0] RST_VAL =
        {{(REG_NUM - 1 - CH_NUM){8'h00}}, {CH_NUM{8'hFF}}, 8'h00},
    parameter logic [REG_NUM*8-1:0] PROT_MASK =
        {{(REG_NUM*8 - 8){1'b0}}, 8'h20}
) (
    input  logic                         clk,
    input  logic                         rst,
    cfg_bank_if.slave                    pi,
    input  logic                         ce_i,
    output logic [REG_NUM-1:0][7:0]      cfg_o,
    output logic [CH_NUM-1:0][7:0]       vol_o,
    output logic [7:0]                   rd_dat_o,
    output logic                         pend_o,
    output logic                         ramp_busy_o
);

    localparam int AW       = $clog2(REG_NUM);
    localparam int DATA_NUM = REG_NUM - 2;
    localparam int A_LOCK   = a_lock(REG_NUM);
    localparam int A_CMT    = a_cmt(REG_NUM);

    localparam logic [REG_NUM-1:0][7:0] RST_A  = RST_VAL;
    localparam logic [REG_NUM-1:0][7:0] PROT_A = PROT_MASK;

    // Only data registers are stored; the two reserved slots are constant 0.
    logic [DATA_NUM-1:0][7:0] shadow_q, shadow_d;
    logic [DATA_NUM-1:0][7:0] live_q,   live_d;
    logic                     pend_q,     pend_d;
    logic                     unlocked_q, unlocked_d;
    logic [7:0]               rd_dat_q,   rd_dat_d;

    logic                     wr;
    acc_kind_t                acc;
    logic [CH_NUM-1:0]        ch_busy;

    assign wr = pi.we_sync & ce_i;

    always_comb begin
        acc = ACC_DATA;
        if (pi.addr == AW'(A_CMT)) begin
            acc = ACC_CMT;
        end else if (pi.addr == AW'(A_LOCK)) begin
            acc = ACC_LOCK;
        end
    end

    always_comb begin
        shadow_d   = shadow_q;
        live_d     = live_q;
        pend_d     = pend_q;
        unlocked_d = unlocked_q;
        if (wr) begin
            case (acc)
                ACC_CMT: begin
                    if (pi.dato[CMT_APPLY]) begin
                        live_d     = shadow_q;
                        pend_d     = 1'b0;
                        unlocked_d = 1'b0;
                    end else if (pi.dato[CMT_DISCARD]) begin
                        shadow_d = live_q;
                        pend_d   = 1'b0;
                    end
                end
                ACC_LOCK: begin
                    unlocked_d = (pi.dato == CFG_UNLOCK_KEY);
                end
                default: begin
                    if (unlocked_q) begin
                        shadow_d[pi.addr] = pi.dato;
                    end else begin
                        // Protected bits keep their shadow value while locked.
                        shadow_d[pi.addr] = (pi.dato & ~PROT_A[pi.addr])
                                          | (shadow_q[pi.addr] & PROT_A[pi.addr]);
                    end
                    pend_d = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        if (pi.addr == AW'(A_CMT)) begin
            rd_dat_d = status_byte(pend_q, unlocked_q, ramp_busy_o);
        end else begin
            rd_dat_d = cfg_o[pi.addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= RST_A[DATA_NUM-1:0];
            live_q     <= RST_A[DATA_NUM-1:0];
            pend_q     <= 1'b0;
            unlocked_q <= 1'b0;
            rd_dat_q   <= 8'h00;
        end else begin
            shadow_q   <= shadow_d;
            live_q     <= live_d;
            pend_q     <= pend_d;
            unlocked_q <= unlocked_d;
            rd_dat_q   <= rd_dat_d;
        end
    end

    assign cfg_o    = {16'h0000, live_q};
    assign rd_dat_o = rd_dat_q;
    assign pend_o   = pend_q;

    generate
        if (RAMP_DIV > 0) begin : g_ramp
            localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
            localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);

            logic [DW-1:0] div_q;
            logic          tick;

            assign tick = (div_q == DIV_LAST);

            always_ff @(posedge clk) begin
                if (rst) begin
                    div_q <= '0;
                end else if (tick) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_q + DW'(1);
                end
            end

            // Targets come from the registered live set, so a tick on the
            // commit edge still steps toward the previous target.
            for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
                vol_ramp u_vol_ramp (
                    .clk       (clk),
                    .rst       (rst),
                    .tick_i    (tick),
                    .target_i  (cfg_o[1+c]),
                    .rst_val_i (RST_A[1+c]),
                    .vol_o     (vol_o[c]),
                    .busy_o    (ch_busy[c])
                );
            end
        end else begin : g_bypass
            for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
                assign vol_o[c]   = cfg_o[1+c];
                assign ch_busy[c] = 1'b0;
            end
        end
    endgenerate

    assign ramp_busy_o = |ch_busy;

endmodule

// File: tb/tb_cfg_bank.sv
module tb_cfg_bank;

    localparam int REG_NUM = 16;
    localparam int CH_NUM  = 2;
    localparam int AW      = 4;
    localparam logic [3:0] A_LOCK = 4'd14;
    localparam logic [3:0] A_CMT  = 4'd15;

    localparam int SEL_CFG  = 0;
    localparam int SEL_VOL  = 1;
    localparam int SEL_RD   = 2;
    localparam int SEL_PEND = 3;
    localparam int SEL_BUSY = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;

    always #5 clk = ~clk;

    cfg_bank_if #(.AW(AW)) pi_if ();

    logic [REG_NUM-1:0][7:0] cfg;
    logic [CH_NUM-1:0][7:0]  vol;
    logic [7:0]              rd_dat;
    logic                    pend;
    logic                    ramp_busy;

    cfg_bank #(
        .REG_NUM  (REG_NUM),
        .CH_NUM   (CH_NUM),
        .RAMP_DIV (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pi          (pi_if),
        .ce_i        (ce),
        .cfg_o       (cfg),
        .vol_o       (vol),
        .rd_dat_o    (rd_dat),
        .pend_o      (pend),
        .ramp_busy_o (ramp_busy)
    );

    typedef struct {
        int         cyc;
        int         sel;
        int         idx;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   div_m  = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference phase of the free-running divider (RAMP_DIV = 4).
    always @(posedge clk) begin
        if (rst) div_m <= 0;
        else     div_m <= (div_m == 3) ? 0 : div_m + 1;
    end

    function automatic logic [7:0] actual(input int sel, input int idx);
        case (sel)
            SEL_CFG:  return cfg[idx];
            SEL_VOL:  return vol[idx];
            SEL_RD:   return rd_dat;
            SEL_PEND: return {7'd0, pend};
            default:  return {7'd0, ramp_busy};
        endcase
    endfunction

    task automatic expect_at(input int dly, input int sel, input int idx,
                             input logic [7:0] e, input string name);
        exp_t it;
        it.cyc  = cyc + dly;
        it.sel  = sel;
        it.idx  = idx;
        it.exp  = e;
        it.name = name;
        sb.push_back(it);
    endtask

    exp_t       mon_it;
    logic [7:0] mon_act;

    always begin
        @(negedge clk);
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_it  = sb.pop_front();
            mon_act = actual(mon_it.sel, mon_it.idx);
            n_chk++;
            if (mon_it.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check missed cycle %0d (now %0d), actual %02h required %02h",
                         mon_it.name, mon_it.cyc, cyc, mon_act, mon_it.exp);
            end else if (mon_act !== mon_it.exp) begin
                n_fail++;
                $display("FAIL %s: actual %02h required %02h at cycle %0d",
                         mon_it.name, mon_act, mon_it.exp, cyc);
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        pi_if.we_sync = 1'b1;
        pi_if.addr    = a;
        pi_if.dato    = d;
        ce            = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pi_if.we_sync = 1'b0;
        ce            = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e, input string name);
        pi_if.addr = a;
        @(posedge clk);
        @(negedge clk);
        expect_at(0, SEL_RD, 0, e, name);
    endtask

    // Issue a commit so that its edge is also a divider tick.
    task automatic commit_on_tick(input logic [7:0] d);
        int guard;
        guard = 0;
        while (div_m != 3 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) begin
            n_chk++;
            n_fail++;
            $display("FAIL tick_align: divider phase %0d required 3", div_m);
        end
        wr(A_CMT, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        pi_if.we_sync = 1'b0;
        pi_if.addr    = '0;
        pi_if.dato    = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        expect_at(0, SEL_CFG, 0, 8'h00, "rst_cfg0");
        expect_at(0, SEL_CFG, 1, 8'hFF, "rst_cfg1");
        expect_at(0, SEL_CFG, 2, 8'hFF, "rst_cfg2");
        expect_at(0, SEL_CFG, 14, 8'h00, "rst_cfg_lock");
        expect_at(0, SEL_CFG, 15, 8'h00, "rst_cfg_cmt");
        expect_at(0, SEL_VOL, 0, 8'hFF, "rst_vol0");
        expect_at(0, SEL_VOL, 1, 8'hFF, "rst_vol1");
        expect_at(0, SEL_PEND, 0, 8'h00, "rst_pend");
        expect_at(0, SEL_BUSY, 0, 8'h00, "rst_busy");
        rd(A_CMT, 8'h00, "rst_status");

        // Protection and unlock key
        wr(4'd0, 8'h3F);
        expect_at(0, SEL_PEND, 0, 8'h01, "locked_wr_pend");
        expect_at(0, SEL_CFG, 0, 8'h00, "locked_wr_not_live");
        rd(A_CMT, 8'h01, "status_pend");
        wr(A_CMT, 8'h01);
        expect_at(0, SEL_CFG, 0, 8'h1F, "locked_commit_cfg0");
        expect_at(0, SEL_PEND, 0, 8'h00, "commit_clears_pend");
        wr(A_LOCK, 8'hA5);
        rd(A_CMT, 8'h02, "status_unlocked");
        wr(4'd0, 8'h3F);
        wr(A_CMT, 8'h01);
        expect_at(0, SEL_CFG, 0, 8'h3F, "unlocked_commit_cfg0");
        wr(4'd0, 8'h00);
        wr(A_CMT, 8'h01);
        expect_at(0, SEL_CFG, 0, 8'h20, "relocked_commit_cfg0");
        rd(A_CMT, 8'h00, "status_relocked");
        wr(A_LOCK, 8'h5A);
        rd(A_CMT, 8'h00, "wrong_key_locked");

        // Chip-select gating
        pi_if.we_sync = 1'b1;
        pi_if.addr    = 4'd6;
        pi_if.dato    = 8'hAA;
        ce            = 1'b0;
        @(posedge clk);
        @(negedge clk);
        pi_if.we_sync = 1'b0;
        expect_at(0, SEL_PEND, 0, 8'h00, "no_ce_no_pend");
        wr(A_CMT, 8'h01);
        expect_at(0, SEL_CFG, 6, 8'h00, "no_ce_no_write");

        // Ramp down FF -> FC, commit edge coincides with a tick
        wr(4'd1, 8'hFC);
        commit_on_tick(8'h01);
        expect_at(0, SEL_CFG, 1, 8'hFC, "ramp_cfg1");
        expect_at(0, SEL_VOL, 0, 8'hFF, "ramp_vol0_start");
        expect_at(0, SEL_BUSY, 0, 8'h01, "ramp_busy_start");
        for (int k = 1; k <= 12; k++) begin
            expect_at(k, SEL_VOL, 0, 8'(255 - k / 4), "ramp_vol0");
            expect_at(k, SEL_BUSY, 0, (k < 12) ? 8'h01 : 8'h00, "ramp_busy");
        end
        repeat (12) @(negedge clk);

        // Retarget down, then reverse mid-glide
        wr(4'd1, 8'hF8);
        commit_on_tick(8'h01);
        expect_at(0, SEL_VOL, 0, 8'hFC, "commit_tick_old_target");
        expect_at(4, SEL_VOL, 0, 8'hFB, "glide_fb");
        expect_at(8, SEL_VOL, 0, 8'hFA, "glide_fa");
        repeat (8) @(negedge clk);
        wr(4'd1, 8'hFE);
        commit_on_tick(8'h01);
        expect_at(0, SEL_VOL, 0, 8'hF9, "reverse_old_target_step");
        expect_at(0, SEL_CFG, 1, 8'hFE, "reverse_cfg1");
        expect_at(4, SEL_VOL, 0, 8'hFA, "reverse_fa");
        expect_at(8, SEL_VOL, 0, 8'hFB, "reverse_fb");
        expect_at(12, SEL_VOL, 0, 8'hFC, "reverse_fc");
        expect_at(16, SEL_VOL, 0, 8'hFD, "reverse_fd");
        expect_at(19, SEL_BUSY, 0, 8'h01, "reverse_busy");
        expect_at(20, SEL_VOL, 0, 8'hFE, "reverse_fe");
        expect_at(20, SEL_BUSY, 0, 8'h00, "reverse_done");
        expect_at(24, SEL_VOL, 0, 8'hFE, "no_overshoot");
        repeat (24) @(negedge clk);

        // Discard
        wr(4'd2, 8'h10);
        expect_at(0, SEL_PEND, 0, 8'h01, "discard_pend_set");
        wr(A_CMT, 8'h02);
        expect_at(0, SEL_CFG, 2, 8'hFF, "discard_cfg2");
        expect_at(0, SEL_PEND, 0, 8'h00, "discard_pend_clr");
        rd(4'd2, 8'hFF, "readback_reg2");
        wr(A_CMT, 8'h01);
        expect_at(0, SEL_CFG, 2, 8'hFF, "discard_shadow_restored");
        wr(A_LOCK, 8'hA5);
        wr(4'd2, 8'h10);
        wr(A_CMT, 8'h02);
        rd(A_CMT, 8'h02, "discard_keeps_unlock");
        wr(A_CMT, 8'h01);

        // Commit both bits / no-op commit
        wr(4'd3, 8'h55);
        wr(A_CMT, 8'h03);
        expect_at(0, SEL_CFG, 3, 8'h55, "commit03_cfg3");
        expect_at(0, SEL_PEND, 0, 8'h00, "commit03_pend");
        rd(4'd3, 8'h55, "readback_reg3");
        wr(4'd4, 8'h66);
        wr(A_CMT, 8'h00);
        expect_at(0, SEL_CFG, 4, 8'h00, "commit00_nochange");
        expect_at(0, SEL_PEND, 0, 8'h01, "commit00_pend_kept");
        rd(A_CMT, 8'h01, "commit00_status");
        wr(A_CMT, 8'h02);
        rd(A_LOCK, 8'h00, "readback_lock_zero");

        // Reset in the middle of a glide
        wr(4'd1, 8'h00);
        commit_on_tick(8'h01);
        expect_at(4, SEL_VOL, 0, 8'hFD, "preglide_fd");
        expect_at(4, SEL_BUSY, 0, 8'h01, "preglide_busy");
        repeat (5) @(negedge clk);
        wr(4'd5, 8'h77);
        expect_at(0, SEL_PEND, 0, 8'h01, "prerst_pend");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        expect_at(0, SEL_VOL, 0, 8'hFF, "rst_mid_vol0");
        expect_at(0, SEL_CFG, 1, 8'hFF, "rst_mid_cfg1");
        expect_at(0, SEL_CFG, 3, 8'h00, "rst_mid_cfg3");
        expect_at(0, SEL_PEND, 0, 8'h00, "rst_mid_pend");
        expect_at(0, SEL_BUSY, 0, 8'h00, "rst_mid_busy");
        rst = 1'b0;
        @(negedge clk);
        wr(A_CMT, 8'h01);
        expect_at(0, SEL_CFG, 5, 8'h00, "rst_shadow_cleared");
        expect_at(0, SEL_CFG, 0, 8'h00, "rst_shadow_cfg0");
        expect_at(0, SEL_CFG, 1, 8'hFF, "rst_shadow_cfg1");

        g = 0;
        while (sb.size() > 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        #2;
        if (sb.size() > 0) begin
            n_chk  += sb.size();
            n_fail += sb.size();
            $display("FAIL drain: %0d checks never evaluated, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
